// File: rtl/pe_mac_sys.sv
// pe_mac_sys: systolic signed MAC processing element with first/last framing and operand forwarding.
// Define PE_SAT_EN for a saturating accumulator with a sticky sat_flag; otherwise the sum wraps.
module pe_mac_sys #(
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             fwd_valid,
  output logic [DW-1:0]    fwd_a,
  output logic [DW-1:0]    fwd_b,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             sat_flag
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state_q, state_d;
  logic s1_v_q, s1_v_d, s1_f_q, s1_f_d, s1_l_q, s1_l_d;
  logic signed [2*DW-1:0] s1_p_q, s1_p_d;
  logic fwd_v_q, fwd_v_d;
  logic [DW-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d, base, ext, acc_new;
  logic out_valid_q, out_valid_d, sat_q, sat_d, start, publish;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    start   = s1_v_q & s1_f_q;
    publish = s1_v_q & s1_l_q;
  end
  always_comb state_d = publish ? IDLE : start ? ACC : state_q;
  always_comb begin
    s1_v_d      = in_valid;
    s1_f_d      = in_valid & in_first;
    s1_l_d      = in_valid & in_last;
    s1_p_d      = in_valid ? $signed(in_a) * $signed(in_b) : s1_p_q;
    fwd_v_d     = in_valid;
    fwd_a_d     = in_a;
    fwd_b_d     = in_b;
    ext         = ACC_W'(s1_p_q);
    base        = start ? '0 : acc_q;
    acc_d       = s1_v_q ? acc_new : acc_q;
    cnt_d       = s1_v_q ? (start ? CNT_W'(1) : cnt_q + 1'b1) : cnt_q;
    out_valid_d = publish;
    out_data_d  = publish ? acc_new : out_data_q;
  end
`ifdef PE_SAT_EN
  logic signed [ACC_W:0] sum_w;
  logic ovf;
  // one guard bit exposes overflow; clamp towards the sign of the true sum
  always_comb begin
    sum_w   = (ACC_W+1)'(base) + (ACC_W+1)'(ext);
    ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    acc_new = ovf ? (sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                  : sum_w[ACC_W-1:0];
    sat_d   = s1_v_q ? ((start ? 1'b0 : sat_q) | ovf) : sat_q;
  end
`else
  always_comb begin
    acc_new = base + ext;
    sat_d   = 1'b0;
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s1_v_q      <= 1'b0;
      s1_f_q      <= 1'b0;
      s1_l_q      <= 1'b0;
      s1_p_q      <= '0;
      fwd_v_q     <= 1'b0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_v_q      <= s1_v_d;
      s1_f_q      <= s1_f_d;
      s1_l_q      <= s1_l_d;
      s1_p_q      <= s1_p_d;
      fwd_v_q     <= fwd_v_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end
  assign fwd_valid = fwd_v_q;
  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign acc_out   = acc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign beat_cnt  = cnt_q;
  assign sat_flag  = sat_q;
endmodule

// File: tb/tb_pe_mac_sys.sv
// tb_pe_mac_sys: table-driven vectors with a result scoreboard, plus overflow and reset sequences.
module tb_pe_mac_sys;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic fwd_valid, out_valid, sat_flag;
  logic [7:0] fwd_a, fwd_b, beat_cnt;
  logic [23:0] acc_out, out_data;
  logic v2 = 1'b0, f2 = 1'b0, l2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0;
  logic fwd_valid_2, out_valid_2, sat_flag_2;
  logic [7:0] fwd_a_2, fwd_b_2, beat_cnt_2;
  logic [15:0] acc_out_2, out_data_2;

  pe_mac_sys u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last), .fwd_valid(fwd_valid), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .acc_out(acc_out), .out_valid(out_valid), .out_data(out_data),
    .beat_cnt(beat_cnt), .sat_flag(sat_flag));

  pe_mac_sys #(.DW(8), .ACC_W(16), .CNT_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_a(a2), .in_b(b2),
    .in_first(f2), .in_last(l2), .fwd_valid(fwd_valid_2), .fwd_a(fwd_a_2),
    .fwd_b(fwd_b_2), .acc_out(acc_out_2), .out_valid(out_valid_2), .out_data(out_data_2),
    .beat_cnt(beat_cnt_2), .sat_flag(sat_flag_2));

  int checks = 0, errors = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {logic v; int a; int b; logic f; logic l; int exp_data; int exp_cnt;} vec_t;
  typedef struct {int data; int cnt;} res_t;
  res_t sb[$];
  vec_t tv[14];
  logic pv = 1'b0;
  int pa = 0, pb = 0;

  logic rst_seen = 1'b1;
  int hold = 0;
  always @(posedge clk) rst_seen <= !rst_n;
  always @(negedge clk) begin
    res_t r;
    if (rst_seen) hold = 0;
    else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got pulse with out_data %0d, expected no pulse", $signed(out_data));
      end else begin
        r = sb.pop_front();
        chk("out_data", $signed(out_data), r.data);
        chk("beat_cnt", beat_cnt, r.cnt);
        chk("acc_out_at_result", $signed(acc_out), r.data);
        hold = r.data;
      end
    end else chk("out_data_hold", $signed(out_data), hold);
  end

  task automatic apply(input logic v, input int a, input int b, input logic f, input logic l,
                       input int ed, input int ec);
    @(negedge clk);
    chk("fwd_valid", fwd_valid, pv);
    if (pv) begin
      chk("fwd_a", $signed(fwd_a), pa);
      chk("fwd_b", $signed(fwd_b), pb);
    end
    in_valid = v;
    in_a = a[7:0];
    in_b = b[7:0];
    in_first = f;
    in_last = l;
    pv = v;
    pa = a;
    pb = b;
    if (v && l) sb.push_back('{ed, ec});
  endtask

  task automatic wait2(output bit got);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      got = out_valid_2;
    end
  endtask

  initial begin
    bit got;
    tv[0]  = '{1'b1,    3,    4, 1'b1, 1'b0,     0, 0};
    tv[1]  = '{1'b1,   -2,    5, 1'b0, 1'b0,     0, 0};
    tv[2]  = '{1'b1,    7,    7, 1'b0, 1'b1,    51, 3};
    tv[3]  = '{1'b1, -128, -128, 1'b1, 1'b1, 16384, 1};
    tv[4]  = '{1'b1,    1,    1, 1'b1, 1'b0,     0, 0};
    tv[5]  = '{1'b1,    2,    2, 1'b0, 1'b0,     0, 0};
    tv[6]  = '{1'b0,    0,    0, 1'b1, 1'b1,     0, 0};
    tv[7]  = '{1'b0,    0,    0, 1'b0, 1'b0,     0, 0};
    tv[8]  = '{1'b1,    3,    3, 1'b0, 1'b1,    14, 3};
    tv[9]  = '{1'b1,    5,    5, 1'b1, 1'b0,     0, 0};
    tv[10] = '{1'b1,    9,    9, 1'b1, 1'b0,     0, 0};
    tv[11] = '{1'b1,    1,    1, 1'b0, 1'b1,    82, 2};
    tv[12] = '{1'b1,  127, -128, 1'b1, 1'b1, -16256, 1};
    tv[13] = '{1'b1,   -1,    1, 1'b0, 1'b1, -16257, 2};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_acc_out", acc_out, 0);
      chk("idle_beat_cnt", beat_cnt, 0);
      chk("idle_fwd_valid", fwd_valid, 0);
      chk("idle_sat_flag", sat_flag, 0);
    end
    foreach (tv[i]) apply(tv[i].v, tv[i].a, tv[i].b, tv[i].f, tv[i].l, tv[i].exp_data, tv[i].exp_cnt);
    repeat (4) apply(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    chk("table_results_drained", sb.size(), 0);
    apply(1'b1, 10, 10, 1'b1, 1'b0, 0, 0);
    apply(1'b1, 10, 10, 1'b0, 1'b0, 0, 0);
    apply(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    rst_n = 1'b1;
    pv = 1'b0;
    apply(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    apply(1'b1, 2, 3, 1'b1, 1'b1, 6, 1);
    repeat (4) apply(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    chk("reset_results_drained", sb.size(), 0);
    @(negedge clk);
    v2 = 1'b1; a2 = 8'h80; b2 = 8'h80; f2 = 1'b1; l2 = 1'b0;
    @(negedge clk);
    f2 = 1'b0; l2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0; l2 = 1'b0;
    wait2(got);
    chk("ovf_pulse", got, 1);
`ifdef PE_SAT_EN
    chk("ovf_out_data", $signed(out_data_2), 32767);
    chk("ovf_sat_flag", sat_flag_2, 1);
`else
    chk("ovf_out_data", $signed(out_data_2), -32768);
    chk("ovf_sat_flag", sat_flag_2, 0);
`endif
    @(negedge clk);
    v2 = 1'b1; a2 = 8'd1; b2 = 8'd1; f2 = 1'b1; l2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0; f2 = 1'b0; l2 = 1'b0;
    wait2(got);
    chk("after_ovf_pulse", got, 1);
    chk("after_ovf_out_data", $signed(out_data_2), 1);
    chk("after_ovf_sat_cleared", sat_flag_2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
